// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: access-size encodings, FSM states, byte-lane constants and lane helpers
package load_store_unit_pkg;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_RSVD = 2'b11} access_size_e;
  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_e;
  localparam logic [3:0] BE_BYTE0   = 4'b1000;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_WORD    = 4'b1111;
  // big-endian: byte offset k lives in lane 3-k, so the byte enable walks down from bit 3
  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
    return size == SZ_BYTE ? BE_BYTE0 >> off :
           size == SZ_HALF ? (off[1] ? BE_HALF_LO : BE_HALF_HI) : BE_WORD;
  endfunction
  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] d);
    return size == SZ_BYTE ? {4{d[7:0]}} : size == SZ_HALF ? {2{d[15:0]}} : d;
  endfunction
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return size == SZ_HALF ? off[0] : size == SZ_WORD ? |off : size == SZ_RSVD;
  endfunction
endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: picks the addressed lane(s) of a read word and sign/zero-extends them
module lsu_load_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = off == 2'd0 ? rdata[31:24] : off == 2'd1 ? rdata[23:16] : off == 2'd2 ? rdata[15:8] : rdata[7:0];
    h = off[1] ? rdata[15:0] : rdata[31:16];
    data = size == SZ_BYTE ? {{24{~uns & b[7]}}, b} :
           size == SZ_HALF ? {{16{~uns & h[15]}}, h} : rdata;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: IDLE/ACCESS/DONE memory access sequencer with timeout; LSU_MISALIGN_TRAP_EN enables alignment traps
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemoryRead,
  input  logic        MemoryWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] read_data,
  input  logic [1:0]  AccessSize,
  input  logic        LoadUnsigned,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] readDataMemory,
  output logic        LSUBusy,
  output logic        LSUDone,
  output logic        AddrError,
  output logic        BusError
);
  state_e      state, state_nx;
  logic [7:0]  cnt;
  logic [1:0]  off, size;
  logic        uns, req, bad, expire, addr_err, bus_err;
  logic [31:0] load_val;
  assign req = MemoryRead | MemoryWrite;
`ifdef LSU_MISALIGN_TRAP_EN
  assign bad = misaligned(AccessSize, ALUResult[1:0]);
`else
  assign bad = 1'b0;
`endif
  // mem_ready in the last allowed cycle wins over the timeout
  assign expire = state == ST_ACCESS && !mem_ready && cnt == 8'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= ST_IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == ST_IDLE ? (req ? (bad ? ST_DONE : ST_ACCESS) : ST_IDLE) :
               state == ST_ACCESS ? (mem_ready || expire ? ST_DONE : ST_ACCESS) : ST_IDLE;
    mem_req = state == ST_ACCESS;
    LSUDone = state == ST_DONE;
    LSUBusy = state != ST_IDLE || req;
    AddrError = addr_err;
    BusError = bus_err;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      off <= '0;
      size <= '0;
      uns <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_be <= '0;
      mem_wdata <= '0;
      readDataMemory <= '0;
      addr_err <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      if (state == ST_IDLE && req) begin
        off <= ALUResult[1:0];
        size <= AccessSize;
        uns <= LoadUnsigned;
        mem_we <= !MemoryRead;
        mem_addr <= {ALUResult[31:2], 2'b00};
        mem_be <= lane_be(AccessSize, ALUResult[1:0]);
        mem_wdata <= lane_wdata(AccessSize, read_data);
      end
      cnt <= state == ST_ACCESS ? cnt + 8'd1 : 8'd0;
      if (state == ST_ACCESS && mem_ready && !mem_we) readDataMemory <= load_val;
      addr_err <= state == ST_IDLE && req && bad;
      bus_err <= expire;
    end
  end
  lsu_load_align u_align (
    .rdata(mem_rdata),
    .off  (off),
    .size (size),
    .uns  (uns),
    .data (load_val)
  );
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed accesses with a queue scoreboard checked by a passive monitor
module tb_load_store_unit;
  import load_store_unit_pkg::*;
  localparam int TO = 16;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif
  typedef struct {logic [3:0] be; logic [31:0] addr; logic [31:0] wdata; logic we;} req_t;
  typedef struct {logic ae; logic bus; logic [31:0] rdm; int len; int done;} rsp_t;
  logic clk, rst, MemoryRead, MemoryWrite, LoadUnsigned, mem_req, mem_we, mem_ready;
  logic LSUBusy, LSUDone, AddrError, BusError;
  logic [31:0] ALUResult, read_data, mem_addr, mem_wdata, mem_rdata, readDataMemory;
  logic [1:0] AccessSize;
  logic [3:0] mem_be;
  req_t rq[$];
  rsp_t sq[$];
  req_t cur;
  rsp_t r_mon;
  int tests = 0, fails = 0, cyc = 0, req_len = 0;
  logic in_req = 1'b0;
  logic [31:0] rdm_model = '0;
  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .MemoryRead(MemoryRead), .MemoryWrite(MemoryWrite),
    .ALUResult(ALUResult), .read_data(read_data), .AccessSize(AccessSize),
    .LoadUnsigned(LoadUnsigned), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .readDataMemory(readDataMemory), .LSUBusy(LSUBusy), .LSUDone(LSUDone),
    .AddrError(AddrError), .BusError(BusError)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      in_req = 1'b0;
      req_len = 0;
    end else begin
      if (mem_req) begin
        if (!in_req) begin
          chk("req_expected", 32'(rq.size() != 0), 1);
          if (rq.size() != 0) cur = rq.pop_front();
          req_len = 0;
        end
        in_req = 1'b1;
        req_len++;
        chk("mem_be", 32'(mem_be), 32'(cur.be));
        chk("mem_addr", mem_addr, cur.addr);
        chk("mem_wdata", mem_wdata, cur.wdata);
        chk("mem_we", 32'(mem_we), 32'(cur.we));
      end else in_req = 1'b0;
      chk("err_without_done", 32'((AddrError | BusError) & ~LSUDone), 0);
      if (LSUDone) begin
        chk("done_expected", 32'(sq.size() != 0), 1);
        if (sq.size() != 0) begin
          r_mon = sq.pop_front();
          chk("AddrError", 32'(AddrError), 32'(r_mon.ae));
          chk("BusError", 32'(BusError), 32'(r_mon.bus));
          chk("readDataMemory", readDataMemory, r_mon.rdm);
          chk("req_cycles", 32'(req_len), 32'(r_mon.len));
          chk("done_cycle", 32'(cyc), 32'(r_mon.done));
        end
        req_len = 0;
      end
    end
  end
  // dly = ACCESS cycles before mem_ready; dly >= TO means memory never answers
  task automatic access(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                        input int dly, input logic [3:0] ebe, input logic [31:0] ewd,
                        input logic [31:0] erd, input logic ae);
    req_t q;
    rsp_t r;
    logic to;
    to = !ae && dly >= TO;
    @(negedge clk);
    chk("idle_busy", 32'(LSUBusy), 0);
    MemoryRead = rd;
    MemoryWrite = wr;
    AccessSize = sz;
    LoadUnsigned = uns;
    ALUResult = addr;
    read_data = wd;
    if (!ae) begin
      q.be = ebe;
      q.addr = {addr[31:2], 2'b00};
      q.wdata = ewd;
      q.we = !rd;
      rq.push_back(q);
    end
    r.ae = ae;
    r.bus = to;
    r.rdm = (rd && !ae && !to) ? erd : rdm_model;
    rdm_model = r.rdm;
    r.len = ae ? 0 : to ? TO : dly + 1;
    r.done = cyc + (ae ? 1 : to ? TO + 1 : dly + 2);
    sq.push_back(r);
    #1 chk("req_busy", 32'(LSUBusy), 1);
    @(negedge clk);
    MemoryRead = 1'b0;
    MemoryWrite = 1'b0;
    if (!ae) begin
      repeat (to ? TO : dly) @(negedge clk);
      if (!to) begin
        mem_ready = 1'b1;
        mem_rdata = rdata;
        @(negedge clk);
        mem_ready = 1'b0;
        mem_rdata = 32'hA5A5A5A5;
      end
    end
    @(negedge clk);
  endtask
  initial begin
    rst = 1'b0;
    MemoryRead = 1'b0;
    MemoryWrite = 1'b0;
    AccessSize = 2'b00;
    LoadUnsigned = 1'b0;
    ALUResult = '0;
    read_data = '0;
    mem_ready = 1'b0;
    mem_rdata = 32'hA5A5A5A5;
    repeat (2) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_be", 32'(mem_be), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rdm", readDataMemory, 0);
    chk("rst_done", 32'({LSUDone, AddrError, BusError, mem_we}), 0);
    rst = 1'b1;
    access(0, 1, SZ_WORD, 0, 32'h100, 32'hDEADBEEF, 0, 0, 4'b1111, 32'hDEADBEEF, 0, 0);
    access(1, 0, SZ_BYTE, 0, 32'h103, 0, 32'h000000F0, 0, 4'b0001, 0, 32'hFFFFFFF0, 0);
    access(1, 0, SZ_BYTE, 1, 32'h103, 0, 32'h000000F0, 1, 4'b0001, 0, 32'h000000F0, 0);
    access(0, 1, SZ_HALF, 0, 32'h102, 32'h00001234, 0, 2, 4'b0011, 32'h12341234, 0, 0);
    access(1, 0, SZ_HALF, 0, 32'h100, 0, 32'h80017777, 0, 4'b1100, 0, 32'hFFFF8001, 0);
    access(1, 0, SZ_HALF, 1, 32'h102, 0, 32'h1234ABCD, 0, 4'b0011, 0, 32'h0000ABCD, 0);
    access(1, 0, SZ_BYTE, 0, 32'h101, 0, 32'h11A23344, 0, 4'b0100, 0, 32'hFFFFFFA2, 0);
    access(1, 0, SZ_WORD, 0, 32'h204, 0, 32'hCAFEF00D, 3, 4'b1111, 0, 32'hCAFEF00D, 0);
    access(0, 1, SZ_BYTE, 0, 32'h202, 32'hFFFFFF5A, 0, 0, 4'b0010, 32'h5A5A5A5A, 0, 0);
    access(1, 1, SZ_WORD, 0, 32'h10C, 32'h77777777, 32'h13579BDF, 0, 4'b1111, 32'h77777777, 32'h13579BDF, 0);
    access(1, 0, SZ_WORD, 0, 32'h300, 0, 32'h99999999, 255, 4'b1111, 0, 0, 0);
    access(1, 0, SZ_WORD, 0, 32'h304, 0, 32'h0BADF00D, TO - 1, 4'b1111, 0, 32'h0BADF00D, 0);
    access(1, 0, SZ_WORD, 0, 32'h101, 0, 32'h01020304, 0, 4'b1111, 0, 32'h01020304, TRAP);
    access(1, 0, SZ_RSVD, 0, 32'h108, 0, 32'h55AA55AA, 0, 4'b1111, 0, 32'h55AA55AA, TRAP);
    @(negedge clk);
    MemoryRead = 1'b1;
    AccessSize = SZ_WORD;
    ALUResult = 32'h400;
    rq.push_back('{be: 4'b1111, addr: 32'h400, wdata: 32'h0, we: 1'b0});
    @(negedge clk);
    MemoryRead = 1'b0;
    @(negedge clk);
    chk("mid_access_req", 32'(mem_req), 1);
    #2 rst = 1'b0;
    #1 chk("rst_drops_req", 32'(mem_req), 0);
    chk("rst_no_done", 32'(LSUDone), 0);
    chk("rst_clears_rdm", readDataMemory, 0);
    rdm_model = '0;
    @(negedge clk);
    rst = 1'b1;
    access(1, 0, SZ_WORD, 0, 32'h404, 0, 32'h600DCAFE, 1, 4'b1111, 0, 32'h600DCAFE, 0);
    repeat (5) @(negedge clk);
    chk("sq_drained", 32'(sq.size()), 0);
    chk("rq_drained", 32'(rq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
